// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiplier/divider start controller.
package multdiv_pkg;

  // Per-channel life cycle of one multiply/divide request.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DRAIN = 2'd3
  } chan_state_t;

  // Width of a counter able to hold 0..max_cycles.
  function automatic int cnt_width(input int max_cycles);
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/multdiv_start_chan.sv
// One request channel: turns a level request into a single start pulse,
// tracks the op until done / withdrawal / watchdog, then waits for the
// request to drop before it can start again.
module multdiv_start_chan
  import multdiv_pkg::*;
#(
  parameter int MAX_CYCLES = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic assert_req,
  input  logic done,
  input  logic grant,
  output logic start,
  output logic busy,
  output logic idle,
  output logic cancel,
  output logic timeout
);

  localparam int CW = cnt_width(MAX_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CYCLES - 1);

  chan_state_t   state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          cancel_reg, cancel_next;
  logic          timeout_reg, timeout_next;

  // Next-state, counter and pulse decisions; done beats cancel beats timeout.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    cancel_next  = 1'b0;
    timeout_next = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (assert_req && grant) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        cnt_next = cnt_reg + CW'(1);
        if (done) begin
          state_next = assert_req ? DRAIN : IDLE;
        end else if (!assert_req) begin
          state_next  = IDLE;
          cancel_next = 1'b1;
        end else begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (done) begin
          state_next = assert_req ? DRAIN : IDLE;
        end else if (!assert_req) begin
          state_next  = IDLE;
          cancel_next = 1'b1;
        end else if (cnt_reg == CNT_LAST) begin
          state_next   = DRAIN;
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DRAIN: begin
        // Holding off until the request drops makes starts edge-based.
        if (!assert_req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counter and pulse registers; reset clears everything at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      cancel_reg  <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      cancel_reg  <= cancel_next;
      timeout_reg <= timeout_next;
    end
  end

  assign start   = (state_reg == START);
  assign busy    = (state_reg == START) || (state_reg == BUSY);
  assign idle    = (state_reg == IDLE);
  assign cancel  = cancel_reg;
  assign timeout = timeout_reg;

endmodule

// File: rtl/multdiv_start_ctrl.sv
// Start-pulse and in-flight tracker for the mult/div units: NCH channels
// plus optional exclusive arbitration (lowest index wins).
module multdiv_start_ctrl
  import multdiv_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int MAX_CYCLES = 40,
  parameter bit EXCLUSIVE  = 1'b0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [NCH-1:0] assert_req,
  input  logic [NCH-1:0] done,
  output logic [NCH-1:0] start,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] cancel,
  output logic [NCH-1:0] timeout,
  output logic           in_flight
);

  logic [NCH-1:0] idle;
  logic [NCH-1:0] grant;

  generate
    if (EXCLUSIVE) begin : g_excl
      // Requesting idle channels; a grant needs no lower claimant and no
      // channel in START/BUSY (registered), so a handover costs one cycle.
      logic [NCH-1:0] claim;
      logic [NCH:0]   lower_claim;
      logic           any_busy;
      assign any_busy       = |busy;
      assign lower_claim[0] = 1'b0;
      for (genvar gi = 0; gi < NCH; gi++) begin : g_arb
        assign claim[gi]          = assert_req[gi] & idle[gi];
        assign lower_claim[gi+1]  = lower_claim[gi] | claim[gi];
        assign grant[gi]          = claim[gi] & ~lower_claim[gi] & ~any_busy;
      end
    end else begin : g_free
      assign grant = '1;
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      multdiv_start_chan #(
        .MAX_CYCLES(MAX_CYCLES)
      ) u_chan (
        .clock     (clock),
        .reset     (reset),
        .assert_req(assert_req[gi]),
        .done      (done[gi]),
        .grant     (grant[gi]),
        .start     (start[gi]),
        .busy      (busy[gi]),
        .idle      (idle[gi]),
        .cancel    (cancel[gi]),
        .timeout   (timeout[gi])
      );
    end
  endgenerate

  assign in_flight = |busy;

endmodule

// File: tb/tb_multdiv_start_ctrl.sv
// Bench for multdiv_start_ctrl: one free-running instance and one exclusive
// instance, a per-cycle reference model feeding expectation queues, and a
// negedge monitor that pops and compares.
module tb_multdiv_start_ctrl;

  localparam int NF = 2;
  localparam int MF = 8;
  localparam int NE = 3;
  localparam int ME = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic [NF-1:0] req_f, done_f, start_f, busy_f, cancel_f, timeout_f;
  logic          inflight_f;
  logic [NE-1:0] req_e, done_e, start_e, busy_e, cancel_e, timeout_e;
  logic          inflight_e;

  multdiv_start_ctrl #(.NCH(NF), .MAX_CYCLES(MF), .EXCLUSIVE(1'b0)) u_free (
    .clock(clock), .reset(reset), .assert_req(req_f), .done(done_f),
    .start(start_f), .busy(busy_f), .cancel(cancel_f), .timeout(timeout_f),
    .in_flight(inflight_f)
  );

  multdiv_start_ctrl #(.NCH(NE), .MAX_CYCLES(ME), .EXCLUSIVE(1'b1)) u_excl (
    .clock(clock), .reset(reset), .assert_req(req_e), .done(done_e),
    .start(start_e), .busy(busy_e), .cancel(cancel_e), .timeout(timeout_e),
    .in_flight(inflight_e)
  );

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] bs;
    logic [3:0] cn;
    logic [3:0] to;
    logic       inf;
  } obs_t;

  obs_t q_f[$];
  obs_t q_e[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Abstract model: per channel an "op active" flag, its age in cycles since
  // the start pulse, and a "must see request drop" flag.
  bit m_act[2][4];
  int m_age[2][4];
  bit m_blk[2][4];

  task automatic model_clear();
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 4; i++) begin
        m_act[u][i] = 1'b0;
        m_age[u][i] = 0;
        m_blk[u][i] = 1'b0;
      end
  endtask

  task automatic model_step(input int u, input int nch, input bit excl, input int maxc,
                            input logic [3:0] r, input logic [3:0] d, output obs_t o);
    bit any_act;
    bit taken;
    bit grant[4];
    any_act = 1'b0;
    taken   = 1'b0;
    o       = '0;
    for (int i = 0; i < nch; i++) any_act |= m_act[u][i];
    for (int i = 0; i < nch; i++) begin
      grant[i] = !excl;
      if (excl && !any_act && !taken && r[i] && !m_act[u][i] && !m_blk[u][i]) begin
        grant[i] = 1'b1;
        taken    = 1'b1;
      end
    end
    for (int i = 0; i < nch; i++) begin
      if (m_act[u][i]) begin
        if (d[i]) begin
          m_act[u][i] = 1'b0;
          m_blk[u][i] = r[i];
        end else if (!r[i]) begin
          m_act[u][i] = 1'b0;
          o.cn[i]     = 1'b1;
        end else if (m_age[u][i] == maxc - 1) begin
          m_act[u][i] = 1'b0;
          m_blk[u][i] = 1'b1;
          o.to[i]     = 1'b1;
        end else begin
          m_age[u][i]++;
        end
      end else if (m_blk[u][i]) begin
        if (!r[i]) m_blk[u][i] = 1'b0;
      end else if (r[i] && grant[i]) begin
        m_act[u][i] = 1'b1;
        m_age[u][i] = 0;
      end
      o.st[i] = m_act[u][i] && (m_age[u][i] == 0);
      o.bs[i] = m_act[u][i];
      o.inf   = o.inf | m_act[u][i];
    end
  endtask

  obs_t o_f, o_e;

  // Reference model: advance on every sampling edge and queue expectations.
  always @(posedge clock) begin
    if (reset) begin
      model_step(0, NF, 1'b0, MF, 4'(req_f), 4'(done_f), o_f);
      q_f.push_back(o_f);
      model_step(1, NE, 1'b1, ME, 4'(req_e), 4'(done_e), o_e);
      q_e.push_back(o_e);
    end
    cyc++;
  end

  obs_t a_f, e_f, a_e, e_e;

  // Monitor: compare DUT outputs mid-cycle against queued expectations.
  always @(negedge clock) begin
    if (reset) begin
      if (q_f.size() > 0) begin
        e_f = q_f.pop_front();
        a_f = {4'(start_f), 4'(busy_f), 4'(cancel_f), 4'(timeout_f), inflight_f};
        n_checks++;
        if (a_f !== e_f) begin
          n_fail++;
          $display("FAIL free_cycle%0d: got st=%b bs=%b cn=%b to=%b inf=%b, required st=%b bs=%b cn=%b to=%b inf=%b",
                   cyc, a_f.st, a_f.bs, a_f.cn, a_f.to, a_f.inf, e_f.st, e_f.bs, e_f.cn, e_f.to, e_f.inf);
        end else begin
          $display("free cycle %0d ok: st=%b bs=%b cn=%b to=%b", cyc, a_f.st, a_f.bs, a_f.cn, a_f.to);
        end
      end
      if (q_e.size() > 0) begin
        e_e = q_e.pop_front();
        a_e = {4'(start_e), 4'(busy_e), 4'(cancel_e), 4'(timeout_e), inflight_e};
        n_checks++;
        if (a_e !== e_e) begin
          n_fail++;
          $display("FAIL excl_cycle%0d: got st=%b bs=%b cn=%b to=%b inf=%b, required st=%b bs=%b cn=%b to=%b inf=%b",
                   cyc, a_e.st, a_e.bs, a_e.cn, a_e.to, a_e.inf, e_e.st, e_e.bs, e_e.cn, e_e.to, e_e.inf);
        end else begin
          $display("excl cycle %0d ok: st=%b bs=%b cn=%b to=%b", cyc, a_e.st, a_e.bs, a_e.cn, a_e.to);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    logic [16:0] got;
    got = {start_f, busy_f, cancel_f, timeout_f, inflight_f,
           start_e, busy_e, cancel_e, timeout_e, inflight_e};
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL %s: outputs=%b, required all zero", name, got);
    end else begin
      $display("%s ok: all outputs zero", name);
    end
  endtask

  initial begin
    reset  = 1'b0;
    req_f  = '0;
    done_f = '0;
    req_e  = '0;
    done_e = '0;
    model_clear();
    tick(3);
    check_all_zero("reset_state");
    reset = 1'b1;
    tick(2);

    // Free mode: start, done 5 cycles after start, request then dropped.
    req_f[0] = 1'b1;
    tick(6);
    done_f[0] = 1'b1;
    tick(1);
    done_f[0] = 1'b0;
    tick(3);
    req_f[0] = 1'b0;
    tick(2);

    // Withdraw in BUSY -> cancel; withdraw together with done -> no cancel.
    req_f[1] = 1'b1;
    tick(3);
    req_f[1] = 1'b0;
    tick(2);
    req_f[1] = 1'b1;
    tick(3);
    req_f[1]  = 1'b0;
    done_f[1] = 1'b1;
    tick(1);
    done_f[1] = 1'b0;
    tick(2);

    // Free-mode watchdog with request held well past the limit.
    req_f[0] = 1'b1;
    tick(12);
    req_f[0] = 1'b0;
    tick(2);

    // Exclusive: simultaneous requests, ch0 first, handover to ch1.
    req_e = 3'b011;
    tick(3);
    done_e[0] = 1'b1;
    req_e[0]  = 1'b0;
    tick(1);
    done_e[0] = 1'b0;
    tick(4);
    done_e[1] = 1'b1;
    tick(1);
    done_e[1] = 1'b0;
    tick(2);
    req_e = '0;
    tick(2);

    // Exclusive watchdog (limit 4) on the highest channel.
    req_e[2] = 1'b1;
    tick(8);
    req_e[2] = 1'b0;
    tick(2);

    // Asynchronous reset mid-BUSY, released with requests still held.
    req_f[0] = 1'b1;
    req_e[1] = 1'b1;
    tick(3);
    #2;
    reset = 1'b0;
    q_f.delete();
    q_e.delete();
    model_clear();
    #1;
    check_all_zero("async_reset_mid_busy");
    tick(2);
    #2;
    reset = 1'b1;
    tick(5);
    req_f = '0;
    req_e = '0;
    tick(3);

    // Random phase: sticky requests with occasional toggles, sparse dones.
    repeat (1500) begin
      for (int i = 0; i < NF; i++) begin
        if ($urandom_range(0, 7) == 0) req_f[i] = ~req_f[i];
        done_f[i] = ($urandom_range(0, 5) == 0);
      end
      for (int i = 0; i < NE; i++) begin
        if ($urandom_range(0, 7) == 0) req_e[i] = ~req_e[i];
        done_e[i] = ($urandom_range(0, 5) == 0);
      end
      tick(1);
    end
    req_f  = '0;
    done_f = '0;
    req_e  = '0;
    done_e = '0;
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_start_ctrl.md
# multdiv_start_ctrl

Parametrised start-pulse and in-flight tracker between the decode stage and the multiplier/divider units. It turns each channel's level "assert" request into exactly one registered start pulse. It then holds the channel busy until the unit reports done, the request is withdrawn, or a watchdog expires. An optional exclusive mode lets only one channel be in flight at a time, with fixed lowest-index priority.

## Interface
- NCH, 2: number of request channels (ch0 = mult, ch1 = div by convention); 1..8.
- MAX_CYCLES, 40: watchdog limit in cycles from start; ≥2.
- EXCLUSIVE, 0: 1 = at most one channel in START/BUSY at a time.
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces all state to reset values immediately.
- assert_req  in  NCH  level request per channel, held high while the op is wanted.
- done  in  NCH  per-channel completion, one-cycle pulse from the unit.
- start  out  NCH  one-cycle start pulse per accepted request.
- busy  out  NCH  channel in START or BUSY.
- cancel  out  NCH  one-cycle pulse: request withdrawn before done.
- timeout  out  NCH  one-cycle pulse: watchdog expired.
- in_flight  out  1  OR of busy.

## Operation
- Each channel has its own FSM with states IDLE, START, BUSY and DRAIN. It also has a cycle counter of width $clog2(MAX_CYCLES+1).
- IDLE: if assert_req=1 and the channel holds a grant, go to START and clear the counter. Otherwise stay in IDLE.
- START: this is a 1-cycle state. If done=1, go to DRAIN, or to IDLE if assert_req=0. Else if assert_req=0, go to IDLE and pulse cancel. Else go to BUSY. The counter increments.
- BUSY: done=1 goes to DRAIN, or to IDLE if assert_req=0. Else assert_req=0 goes to IDLE and pulses cancel. Else if counter==MAX_CYCLES-1, go to DRAIN and pulse timeout. Else stay in BUSY and increment the counter.
- DRAIN: wait for assert_req=0, then go to IDLE. No new start until the request drops, which makes the block edge-based.
- Priority when events coincide on one edge: done > cancel > timeout.
- Grant, EXCLUSIVE=0: always granted.
- Grant, EXCLUSIVE=1:
  - Granted only if no channel is in START/BUSY, judged from registered state.
  - Among requesting IDLE channels, the lowest index wins.
  - Losers stay IDLE and retry every cycle while their request is held.
  - A channel leaving BUSY and another requesting on the same edge gives one idle cycle before the new start.
- Outputs:
  - start is Moore, high iff state==START.
  - busy is high iff state is START or BUSY.
  - cancel and timeout are registered pulses.
- Reset values: every output is 0, all FSMs are IDLE, all counters are 0.
- Reset mid-operation: returns to IDLE with no cancel or timeout pulse. A request still held after reset release starts again.

## Timing
- Latency: assert_req first sampled high at edge k (granted) gives start high during cycle k→k+1. Exactly one cycle.
- A done sampled at edge j drops busy after edge j.
- cancel or timeout is high for the one cycle following the deciding edge.
- Watchdog: with no done, timeout is high in cycle MAX_CYCLES after start.
- No combinational path from any input to any output.

## Structure
- Package multdiv_pkg: the state enum typedef (IDLE/START/BUSY/DRAIN) and the counter-width function/localparam.
- Sub-module multdiv_start_chan: one channel's FSM, counter and pulses, with a grant input. It is instantiated NCH times in a generate loop.
- The top level holds only grant arbitration and the in_flight OR.

## Test plan
- NCH=2, EXCLUSIVE=0. Raise assert_req[0] and hold it; done[0] follows 5 cycles after start → one start[0] pulse 1 cycle after the request, busy[0] high for 6 cycles, no second start while the request is held.
- EXCLUSIVE=1. Raise both requests on the same edge → start[0] first. After done[0] and deassert of request 0, there is one idle cycle, then start[1]. start[1] never overlaps busy[0].
- MAX_CYCLES=4, no done → timeout pulse 4 cycles after start, busy falls, the channel stays in DRAIN until the request drops, and no second start occurs.
- Drop assert_req in BUSY → one cancel pulse and IDLE. Drop assert_req together with done → no cancel, IDLE.
- Pull reset low asynchronously mid-BUSY → all outputs 0 immediately. Release it with the request held → a fresh start 1 cycle after the first sampling edge.
